// File: rtl/dinorun_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dinorun_pkg
// Purpose  : Shared types and constants for the dinorun game blocks. Holds
//            the game-flow state encoding, the screen geometry constants and
//            a width helper for counters sized from parameters.
// Ports    : none (package)
// Revision : 2.0 - state_t widened to 3 bits for PAUSED and GAME_OVER
// ============================================================================
package dinorun_pkg;

    localparam int c_SCREEN_WIDTH = 640;
    localparam int c_GROUND       = 400;

    // The original STARTING/PLAYING/HIT encodings are kept as-is so existing
    // consumers of the 2-bit value still decode them the same way.
    typedef enum logic [2:0] {
        STARTING  = 3'd0,
        PLAYING   = 3'd1,
        HIT       = 3'd2,
        PAUSED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    // Bits needed to hold the values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : dinorun_pkg
`default_nettype wire

// File: rtl/dinorun_score_counter.sv
`default_nettype none
// ============================================================================
// Module   : dinorun_score_counter
// Purpose  : Score, difficulty level and high-score bookkeeping.
//            Score saturates at all-ones. Level advances every LEVEL_STEP
//            points via a points-since-level counter and saturates at
//            MAX_LEVEL. High score captures max(high, score) on request.
// Ports    : clk_i, rst_i       clock, asynchronous active-high reset
//            inc_i              add one point this cycle
//            clear_i            zero score, level and level progress
//            latch_high_i       update high score with the current score
//            score_o            current score
//            level_o            current difficulty level
//            high_score_o       best score since reset
// Revision : 1.0 - initial release
// ============================================================================
module dinorun_score_counter
    import dinorun_pkg::*;
#(
    parameter int SCORE_WIDTH = 16,
    parameter int LEVEL_STEP  = 100,
    parameter int MAX_LEVEL   = 7,
    parameter int LEVEL_W     = cnt_width(MAX_LEVEL)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   inc_i,
    input  logic                   clear_i,
    input  logic                   latch_high_i,
    output logic [SCORE_WIDTH-1:0] score_o,
    output logic [LEVEL_W-1:0]     level_o,
    output logic [SCORE_WIDTH-1:0] high_score_o
);

    localparam int                 PTS_W       = cnt_width(LEVEL_STEP - 1);
    localparam logic [PTS_W-1:0]   c_PTS_LAST  = PTS_W'(LEVEL_STEP - 1);
    localparam logic [LEVEL_W-1:0] c_LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

    logic [SCORE_WIDTH-1:0] r_score;
    logic [SCORE_WIDTH-1:0] r_high;
    logic [PTS_W-1:0]       r_pts;
    logic [LEVEL_W-1:0]     r_level;
    logic                   w_score_full;

    assign w_score_full = &r_score;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_score <= '0;
            r_high  <= '0;
            r_pts   <= '0;
            r_level <= '0;
        end else begin
            if (clear_i) begin
                r_score <= '0;
                r_pts   <= '0;
                r_level <= '0;
            end else if (inc_i && !w_score_full) begin
                // A saturated score earns no points, so level progress
                // only moves when the score itself moves.
                r_score <= r_score + SCORE_WIDTH'(1);
                if (r_pts == c_PTS_LAST) begin
                    r_pts <= '0;
                    if (r_level != c_LEVEL_MAX) begin
                        r_level <= r_level + LEVEL_W'(1);
                    end
                end else begin
                    r_pts <= r_pts + PTS_W'(1);
                end
            end
            if (latch_high_i && (r_score > r_high)) begin
                r_high <= r_score;
            end
        end
    end

    assign score_o      = r_score;
    assign level_o      = r_level;
    assign high_score_o = r_high;

endmodule : dinorun_score_counter
`default_nettype wire

// File: rtl/dinorun_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dinorun_game_ctrl
// Purpose  : Game-flow controller: STARTING / PLAYING / PAUSED / HIT /
//            GAME_OVER with lives, timed hit-freeze, post-respawn
//            invulnerability, score, high score and difficulty level.
// Ports    : clk_i, rst_i       clock, asynchronous active-high reset
//            start_i, pause_i   debounced button levels (edge-detected here)
//            collision_i        dino/obstacle overlap level
//            frame_i            one-cycle pulse per video frame
//            state_o            current state
//            title_en_o         title screen visible
//            obstacle_en_o      obstacles move/spawn
//            freeze_o           freeze all motion
//            invuln_o           invulnerability window active
//            lives_o            lives remaining
//            level_o            difficulty level
//            score_o            current score
//            high_score_o       best score since reset
// Revision : 2.0 - pause, lives, freeze/invulnerability timers, scoring
// ============================================================================
module dinorun_game_ctrl
    import dinorun_pkg::*;
#(
    parameter int NUM_LIVES         = 3,
    parameter int SCORE_WIDTH       = 16,
    parameter int LEVEL_STEP        = 100,
    parameter int MAX_LEVEL         = 7,
    parameter int HIT_FREEZE_FRAMES = 60,
    parameter int INVULN_FRAMES     = 90
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             pause_i,
    input  logic                             collision_i,
    input  logic                             frame_i,
    output state_t                           state_o,
    output logic                             title_en_o,
    output logic                             obstacle_en_o,
    output logic                             freeze_o,
    output logic                             invuln_o,
    output logic [$clog2(NUM_LIVES+1)-1:0]   lives_o,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level_o,
    output logic [SCORE_WIDTH-1:0]           score_o,
    output logic [SCORE_WIDTH-1:0]           high_score_o
);

    localparam int LIVES_W = $clog2(NUM_LIVES + 1);
    localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
    localparam int FRZ_W   = cnt_width(HIT_FREEZE_FRAMES);
    localparam int INV_W   = cnt_width(INVULN_FRAMES);

    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic [FRZ_W-1:0]   r_frz;
    logic [INV_W-1:0]   r_inv;
    logic               r_start_d;
    logic               r_pause_d;
    logic               r_armed;

    logic w_start_rise;
    logic w_pause_rise;
    logic w_hit;
    logic w_freeze_done;
    logic w_inc;
    logic w_clear;
    logic w_latch_high;

    // r_armed blocks edge detection for the first cycle after reset so a
    // button held through reset release is not mistaken for a new press.
    assign w_start_rise  = start_i & ~r_start_d & r_armed;
    assign w_pause_rise  = pause_i & ~r_pause_d & r_armed;

    assign w_hit         = (r_state == PLAYING) && collision_i && (r_inv == '0);
    assign w_freeze_done = (r_state == HIT) && frame_i && (r_frz == FRZ_W'(1));

    // Score moves only on a frame in PLAYING that is not preempted by a
    // collision or a pause press in the same cycle.
    assign w_inc         = (r_state == PLAYING) && frame_i && !w_hit && !w_pause_rise;
    assign w_clear       = (r_state == STARTING) && w_start_rise;
    // Score is frozen in HIT, so capturing it on the edge into GAME_OVER
    // records the final score of the game.
    assign w_latch_high  = w_freeze_done && (r_lives == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= STARTING;
            r_lives   <= LIVES_W'(NUM_LIVES);
            r_frz     <= '0;
            r_inv     <= '0;
            r_start_d <= 1'b0;
            r_pause_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_d <= start_i;
            r_pause_d <= pause_i;
            r_armed   <= 1'b1;
            case (r_state)
                STARTING: begin
                    if (w_start_rise) begin
                        r_state <= PLAYING;
                        r_inv   <= '0;
                        r_lives <= LIVES_W'(NUM_LIVES);
                    end
                end
                PLAYING: begin
                    if (w_hit) begin
                        r_state <= HIT;
                        r_lives <= r_lives - LIVES_W'(1);
                        r_frz   <= FRZ_W'(HIT_FREEZE_FRAMES);
                    end else if (w_pause_rise) begin
                        r_state <= PAUSED;
                    end else if (frame_i && (r_inv != '0)) begin
                        r_inv <= r_inv - INV_W'(1);
                    end
                end
                PAUSED: begin
                    if (w_pause_rise) begin
                        r_state <= PLAYING;
                    end
                end
                HIT: begin
                    if (w_freeze_done) begin
                        r_frz <= '0;
                        if (r_lives == '0) begin
                            r_state <= GAME_OVER;
                        end else begin
                            r_state <= PLAYING;
                            r_inv   <= INV_W'(INVULN_FRAMES);
                        end
                    end else if (frame_i && (r_frz != '0)) begin
                        r_frz <= r_frz - FRZ_W'(1);
                    end
                end
                GAME_OVER: begin
                    if (w_start_rise) begin
                        r_state <= STARTING;
                    end
                end
                default: begin
                    r_state <= STARTING;
                end
            endcase
        end
    end

    dinorun_score_counter #(
        .SCORE_WIDTH (SCORE_WIDTH),
        .LEVEL_STEP  (LEVEL_STEP),
        .MAX_LEVEL   (MAX_LEVEL),
        .LEVEL_W     (LEVEL_W)
    ) u_score (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inc_i        (w_inc),
        .clear_i      (w_clear),
        .latch_high_i (w_latch_high),
        .score_o      (score_o),
        .level_o      (level_o),
        .high_score_o (high_score_o)
    );

    assign state_o       = r_state;
    assign title_en_o    = (r_state == STARTING);
    assign obstacle_en_o = (r_state == PLAYING);
    assign freeze_o      = (r_state == PAUSED) || (r_state == HIT) || (r_state == GAME_OVER);
    assign invuln_o      = (r_inv != '0);
    assign lives_o       = r_lives;

endmodule : dinorun_game_ctrl
`default_nettype wire

// File: tb/tb_dinorun_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dinorun_game_ctrl
// Purpose  : Self-checking bench for dinorun_game_ctrl. Directed game
//            scenarios followed by a randomized run, every cycle compared
//            against a game-rule reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dinorun_game_ctrl;
    import dinorun_pkg::*;

    localparam int NL = 2;
    localparam int SW = 4;
    localparam int LS = 3;
    localparam int ML = 2;
    localparam int HF = 2;
    localparam int IF = 2;
    localparam int SCORE_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic start, pause, coll, frame;
    state_t state;
    logic title_en, obstacle_en, freeze, invuln;
    logic [$clog2(NL+1)-1:0] lives;
    logic [$clog2(ML+1)-1:0] level;
    logic [SW-1:0] score, high_score;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model of the game rules
    state_t m_state;
    int m_lives, m_score, m_high, m_inv, m_frz;
    bit m_sprev, m_pprev, m_fresh;

    always #5 clk = ~clk;

    dinorun_game_ctrl #(
        .NUM_LIVES (NL), .SCORE_WIDTH (SW), .LEVEL_STEP (LS),
        .MAX_LEVEL (ML), .HIT_FREEZE_FRAMES (HF), .INVULN_FRAMES (IF)
    ) dut (
        .clk_i (clk), .rst_i (rst), .start_i (start), .pause_i (pause),
        .collision_i (coll), .frame_i (frame), .state_o (state),
        .title_en_o (title_en), .obstacle_en_o (obstacle_en),
        .freeze_o (freeze), .invuln_o (invuln), .lives_o (lives),
        .level_o (level), .score_o (score), .high_score_o (high_score)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = STARTING;
        m_lives = NL;
        m_score = 0;
        m_high  = 0;
        m_inv   = 0;
        m_frz   = 0;
        m_sprev = 1'b0;
        m_pprev = 1'b0;
        m_fresh = 1'b1;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit f);
        bit srise, prise;
        srise = s && !m_sprev && !m_fresh;
        prise = p && !m_pprev && !m_fresh;
        case (m_state)
            STARTING: if (srise) begin
                m_state = PLAYING; m_score = 0; m_inv = 0; m_lives = NL;
            end
            PLAYING: begin
                if (c && m_inv == 0) begin
                    m_state = HIT; m_lives = m_lives - 1; m_frz = HF;
                end else if (prise) begin
                    m_state = PAUSED;
                end else if (f) begin
                    if (m_score < SCORE_MAX) m_score = m_score + 1;
                    if (m_inv > 0) m_inv = m_inv - 1;
                end
            end
            PAUSED: if (prise) m_state = PLAYING;
            HIT: if (f) begin
                if (m_frz == 1) begin
                    m_frz = 0;
                    if (m_lives == 0) begin
                        m_state = GAME_OVER;
                        if (m_score > m_high) m_high = m_score;
                    end else begin
                        m_state = PLAYING; m_inv = IF;
                    end
                end else begin
                    m_frz = m_frz - 1;
                end
            end
            GAME_OVER: if (srise) m_state = STARTING;
            default: m_state = STARTING;
        endcase
        m_sprev = s;
        m_pprev = p;
        m_fresh = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int exp_level;
        exp_level = m_score / LS;
        if (exp_level > ML) exp_level = ML;
        chk({ctx, ".state"},    32'(state),       32'(m_state));
        chk({ctx, ".title"},    32'(title_en),    32'(m_state == STARTING));
        chk({ctx, ".obstacle"}, 32'(obstacle_en), 32'(m_state == PLAYING));
        chk({ctx, ".freeze"},   32'(freeze),
            32'(m_state == PAUSED || m_state == HIT || m_state == GAME_OVER));
        chk({ctx, ".invuln"},   32'(invuln),      32'(m_inv != 0));
        chk({ctx, ".lives"},    32'(lives),       32'(m_lives));
        chk({ctx, ".level"},    32'(level),       32'(exp_level));
        chk({ctx, ".score"},    32'(score),       32'(m_score));
        chk({ctx, ".high"},     32'(high_score),  32'(m_high));
    endtask

    task automatic cycle(input string ctx, input bit s, input bit p, input bit c, input bit f);
        start = s; pause = p; coll = c; frame = f;
        model_step(s, p, c, f);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rs, rp, rc, rf;
        rst = 1'b1; start = 1'b0; pause = 1'b0; coll = 1'b0; frame = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: start a game, 7 frames -> level saturates at 2
        cycle("t1.idle", 0, 0, 0, 0);
        cycle("t1.start", 1, 0, 0, 0);
        repeat (7) cycle("t1.frame", 1, 0, 0, 1);
        chk("t1.state_playing", 32'(state), 32'(PLAYING));
        chk("t1.score7", 32'(score), 32'd7);
        chk("t1.level2", 32'(level), 32'd2);
        chk("t1.title0", 32'(title_en), 32'd0);
        chk("t1.obst1", 32'(obstacle_en), 32'd1);

        // 2: pause, frames while paused, resume
        cycle("t2.pause", 1, 1, 0, 0);
        chk("t2.state_paused", 32'(state), 32'(PAUSED));
        repeat (5) cycle("t2.pframe", 1, 1, 0, 1);
        cycle("t2.rel", 1, 0, 0, 0);
        cycle("t2.resume", 1, 1, 0, 0);
        chk("t2.state_playing", 32'(state), 32'(PLAYING));
        chk("t2.score7", 32'(score), 32'd7);
        cycle("t2.rel2", 1, 0, 0, 0);

        // 3: collision + pause rise + frame together -> collision wins
        cycle("t3.hit", 1, 1, 1, 1);
        chk("t3.state_hit", 32'(state), 32'(HIT));
        chk("t3.lives1", 32'(lives), 32'd1);
        chk("t3.score7", 32'(score), 32'd7);
        cycle("t3.frz1", 1, 0, 0, 1);
        cycle("t3.frz2", 1, 0, 0, 1);
        chk("t3.respawn", 32'(state), 32'(PLAYING));
        chk("t3.invuln1", 32'(invuln), 32'd1);
        cycle("t3.immune1", 1, 0, 1, 1);
        cycle("t3.immune2", 1, 0, 1, 1);
        chk("t3.still_playing", 32'(state), 32'(PLAYING));
        chk("t3.invuln0", 32'(invuln), 32'd0);

        // 4: last life lost -> GAME_OVER, high score kept over a worse game
        cycle("t4.hit", 1, 0, 1, 0);
        repeat (2) cycle("t4.frz", 1, 0, 0, 1);
        chk("t4.gameover", 32'(state), 32'(GAME_OVER));
        chk("t4.lives0", 32'(lives), 32'd0);
        chk("t4.high9", 32'(high_score), 32'd9);
        cycle("t4.rel", 0, 0, 0, 0);
        cycle("t4.to_start", 1, 0, 0, 0);
        chk("t4.starting", 32'(state), 32'(STARTING));
        cycle("t4.rel2", 0, 0, 0, 0);
        cycle("t4.newgame", 1, 0, 0, 0);
        repeat (2) cycle("t4.frame", 1, 0, 0, 1);
        cycle("t4.hitA", 1, 0, 1, 0);
        repeat (4) cycle("t4.frameA", 1, 0, 0, 1);
        cycle("t4.hitB", 1, 0, 1, 0);
        repeat (2) cycle("t4.frameB", 1, 0, 0, 1);
        chk("t4.gameover2", 32'(state), 32'(GAME_OVER));
        chk("t4.high_kept", 32'(high_score), 32'd9);

        // 5: score saturates at 15
        cycle("t5.rel", 0, 0, 0, 0);
        cycle("t5.to_start", 1, 0, 0, 0);
        cycle("t5.rel2", 0, 0, 0, 0);
        cycle("t5.newgame", 1, 0, 0, 0);
        repeat (20) cycle("t5.frame", 1, 0, 0, 1);
        chk("t5.score15", 32'(score), 32'd15);

        // 6: async reset mid-HIT with start held through release
        cycle("t6.hit", 1, 0, 1, 0);
        chk("t6.state_hit", 32'(state), 32'(HIT));
        coll = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        chk("t6.async_state", 32'(state), 32'(STARTING));
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("t6.inreset");
        end
        rst = 1'b0;
        repeat (3) cycle("t6.held", 1, 0, 0, 0);
        chk("t6.no_retrigger", 32'(state), 32'(STARTING));
        cycle("t6.rel", 0, 0, 0, 0);
        cycle("t6.start", 1, 0, 0, 0);
        chk("t6.playing", 32'(state), 32'(PLAYING));

        // randomized play against the model
        rs = 1'b0; rp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) rs = ~rs;
            if ($urandom_range(9, 0) == 0) rp = ~rp;
            rc = ($urandom_range(11, 0) == 0);
            rf = ($urandom_range(2, 0) == 0);
            cycle("rnd", rs, rp, rc, rf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dinorun_game_ctrl
`default_nettype wire
